// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary datapath blocks.
// Trit line encoding plus small elaboration-time helpers.
package ternary_pkg;

    localparam logic [1:0] TRIT_0       = 2'b00;
    localparam logic [1:0] TRIT_1       = 2'b01;
    localparam logic [1:0] TRIT_2       = 2'b10;
    localparam logic [1:0] TRIT_ILLEGAL = 2'b11;

    localparam int TRITS_MAX = 5;

    // 3**n, used to size-check frames at elaboration.
    function automatic longint pow3(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

endpackage

// File: rtl/ternary_trit_decode.sv
// Combinational trit decoder.
// Maps a 2-bit line code to its digit value and an illegal flag.
module ternary_trit_decode
    import ternary_pkg::*;
(
    input  logic [1:0] code,
    output logic [1:0] value,
    output logic       illegal
);

    // Illegal codes contribute zero to the accumulator.
    always_comb begin
        value   = 2'd0;
        illegal = 1'b0;
        unique case (code)
            TRIT_0:  value = 2'd0;
            TRIT_1:  value = 2'd1;
            TRIT_2:  value = 2'd2;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ternary_deserializer.sv
// Ternary-to-binary frame deserializer.
// MSB-first trits accumulate into a frame held in an output register.
module ternary_deserializer #(
    parameter int TRITS = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_trit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    import ternary_pkg::*;

    localparam int CW = $clog2(TRITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(TRITS - 1);

    if (TRITS < 1 || TRITS > TRITS_MAX) begin : g_bad_trits
        $error("ternary_deserializer: TRITS out of range");
    end

    if (pow3(TRITS) > (64'd1 << WIDTH)) begin : g_bad_width
        $error("ternary_deserializer: WIDTH too small");
    end

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             err_acc;

    logic [1:0]       dec_value;
    logic             dec_illegal;

    logic             last;
    logic             accept;
    logic             frame_done;
    logic             frame_err;
    logic [WIDTH-1:0] acc_next;

    ternary_trit_decode u_decode (
        .code    (in_trit),
        .value   (dec_value),
        .illegal (dec_illegal)
    );

    // Only the final trit needs room in the output register.
    always_comb begin
        last     = (cnt == LAST_IDX);
        in_ready = !(last && out_valid && !out_ready);
        accept   = in_valid && in_ready;
        frame_done = accept && last;
        frame_err  = err_acc || dec_illegal;
        acc_next = (acc << 1) + acc + WIDTH'(dec_value);
    end

    // Accumulator: shift in one trit per accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
        end else if (frame_done) begin
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
        end else if (accept) begin
            acc     <= acc_next;
            cnt     <= cnt + 1'b1;
            err_acc <= frame_err;
        end
    end

    // Output register: load on frame completion, drop on take.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (frame_done) begin
            out_valid <= 1'b1;
            out_data  <= frame_err ? '0 : acc_next;
            out_err   <= frame_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ternary_deserializer.sv
// Scoreboard bench for ternary_deserializer (TRITS=5, WIDTH=8).
// Driver pushes expected frames; a monitor pops on each handshake.
module tb_ternary_deserializer;

    localparam int TRITS = 5;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       in_trit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    int checks;
    int fails;
    int cyc;

    logic [WIDTH:0] sb_q[$];

    logic           prev_hold;
    logic [WIDTH:0] prev_out;

    ternary_deserializer #(
        .TRITS (TRITS),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_trit   (in_trit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop on every handshake, and check hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_frame", 32'({out_err, out_data}),
                    32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame: got %0d expected none",
                             {out_err, out_data});
                end else begin
                    chk("frame", 32'({out_err, out_data}),
                        32'(sb_q.pop_front()));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_err, out_data};
        end
    end

    // Present one trit and wait, bounded, for it to be accepted.
    task automatic send(input logic [1:0] t);
        int  n;
        bit  got;
        n   = 0;
        got = 0;
        in_trit  = t;
        in_valid = 1'b1;
        while (!got && n < 50) begin
            #1;
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got 0 expected 1");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_trit  = 2'b00;
    endtask

    task automatic send_frame(input logic [9:0] t,
                              input logic [7:0] exp_data,
                              input logic       exp_err);
        sb_q.push_back({exp_err, exp_data});
        for (int i = 4; i >= 0; i--) begin
            send(t[2*i +: 2]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        idle();
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int macc;
        int mcnt;
        bit merr;
        bit take;
        logic [1:0] t;

        checks    = 0;
        fails     = 0;
        cyc       = 0;
        prev_hold = 1'b0;
        prev_out  = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_trit   = 2'b00;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // All-twos frame with 1-cycle latency and a 1-cycle pulse.
        out_ready = 1'b1;
        send_frame({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 8'd242, 1'b0);
        idle();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'd242);
        @(posedge clk);
        #1;
        chk("pulse_end", 32'(out_valid), 32'd0);

        // Back-to-back frames: 10 trits in 10 cycles.
        c0 = cyc;
        send_frame({2'd1, 2'd0, 2'd2, 2'd1, 2'd0}, 8'd102, 1'b0);
        chk("b2b_first", 32'(out_data), 32'd102);
        send_frame({2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, 8'd1, 1'b0);
        idle();
        chk("b2b_cycles", 32'(cyc - c0), 32'd10);
        chk("b2b_second", 32'(out_data), 32'd1);

        // Illegal code poisons only its own frame.
        send_frame({2'd0, 2'b11, 2'd0, 2'd0, 2'd1}, 8'd0, 1'b1);
        chk("err_flag", 32'(out_err), 32'd1);
        send_frame({2'd0, 2'd0, 2'd0, 2'd1, 2'd0}, 8'd3, 1'b0);
        idle();
        chk("err_cleared", 32'(out_err), 32'd0);
        drain();

        // Backpressure: hold A, stall trit 5, release together.
        out_ready = 1'b0;
        send_frame({2'd1, 2'd0, 2'd2, 2'd1, 2'd0}, 8'd102, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(2'd0);
        end
        in_trit  = 2'd1;
        in_valid = 1'b1;
        #1;
        chk("stall_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_ready2", 32'(in_ready), 32'd0);
        chk("stall_held", 32'(out_data), 32'd102);
        out_ready = 1'b1;
        sb_q.push_back({1'b0, 8'd1});
        c0 = cyc;
        send(2'd1);
        idle();
        chk("release_cycles", 32'(cyc - c0), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_data", 32'(out_data), 32'd1);
        drain();

        // Reset mid-frame discards the partial frame.
        send(2'd2);
        send(2'd1);
        send(2'd2);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        send_frame({2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, 8'd1, 1'b0);
        idle();
        drain();

        // Random handshakes against a reference model.
        macc = 0;
        mcnt = 0;
        merr = 0;
        for (int i = 0; i < 600; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                t = 2'b11;
            end else begin
                t = 2'($urandom_range(0, 2));
            end
            in_trit = t;
            #1;
            take = in_valid && in_ready;
            if (take) begin
                merr = merr || (t == 2'b11);
                macc = macc * 3 + ((t == 2'b11) ? 0 : int'(t));
                mcnt++;
                if (mcnt == TRITS) begin
                    sb_q.push_back({merr, merr ? 8'd0 : 8'(macc)});
                    macc = 0;
                    mcnt = 0;
                    merr = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        idle();
        // Finish any partial frame so the model and DUT line up.
        out_ready = 1'b1;
        while (mcnt != 0) begin
            send(2'd0);
            macc = macc * 3;
            mcnt++;
            if (mcnt == TRITS) begin
                sb_q.push_back({merr, merr ? 8'd0 : 8'(macc)});
                mcnt = 0;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/ternary_deserializer.md
TERNARY_DESERIALIZER -- requirements
Module: ternary_deserializer

Interface
REQ-001 SHALL have parameter TRITS, default 5: number of trits per frame, legal range 1..5.
REQ-002 SHALL have parameter WIDTH, default 8: output width, with 3^TRITS-1 < 2^WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_trit, input, 2 bits: one trit, encoded 2'b00=0, 2'b01=1, 2'b10=2, 2'b11=illegal.
REQ-006 SHALL have port in_valid, input, 1 bit: in_trit holds a trit.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_trit this cycle.
REQ-008 SHALL have port out_data, output, WIDTH bits: binary value of the completed frame.
REQ-009 SHALL have port out_err, output, 1 bit: the completed frame contained at least one illegal code.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data/out_err hold a completed frame.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the frame this cycle.

Function
REQ-012 SHALL accept a trit only on a cycle with in_valid=1 and in_ready=1; trits arrive MSB (most significant trit) first.
REQ-013 SHALL, per accepted trit, update acc <= acc*3 + value and cnt <= cnt+1; arithmetic SHALL be WIDTH bits unsigned with no overflow for legal TRITS.
REQ-014 SHALL treat an illegal code as value 0 in acc and set a frame error flag err_acc.
REQ-015 SHALL, on acceptance of trit number TRITS, load out_data=(err ? 0 : final acc), out_err=err, and clear acc, cnt and err_acc in the same cycle.
REQ-016 SHALL assert out_valid the cycle after the last trit is accepted; latency is 1 cycle.
REQ-017 SHALL hold out_data, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL deassert out_valid on the cycle after out_valid=1 and out_ready=1, unless a new frame completes in that same cycle.
REQ-019 SHALL keep in_ready=1 while assembling trits 1..TRITS-1, even with out_valid=1 and out_ready=0, because the accumulator is separate from the output register.
REQ-020 SHALL drive in_ready=0 only when cnt==TRITS-1 and out_valid=1 and out_ready=0; in_ready SHALL be combinational from state and out_ready.
REQ-021 SHALL, if the last trit is accepted in the same cycle the held frame is taken, load the new frame with out_valid staying 1 and no frame lost or duplicated.
REQ-022 SHALL sustain 1 trit/cycle (one frame per TRITS cycles) when out_ready is held at 1.
REQ-023 SHALL ignore in_trit when in_valid=0; cnt and acc unchanged.
REQ-024 SHALL, for TRITS=1, behave as a registered per-trit decoder, with in_ready = !out_valid || out_ready.

Reset
REQ-025 SHALL, on a rising clk edge with rst_n=0, set out_valid=0, out_data=0, out_err=0, acc=0, cnt=0, err_acc=0.
REQ-026 SHALL drive in_ready=1 during and immediately after reset.
REQ-027 SHALL discard a partially assembled frame and a pending output frame on reset mid-operation; the next accepted trit is trit 1 of a new frame.

Structure
REQ-028 SHALL take the trit encoding constants (TRIT_0, TRIT_1, TRIT_2, TRIT_ILLEGAL) from shared package ternary_pkg, alongside the other ternary blocks.
REQ-029 SHALL use one sub-module ternary_trit_decode, a combinational cell: 2-bit code in; 2-bit value and illegal flag out.
REQ-030 SHALL size cnt as $clog2(TRITS+1) bits in a local parameter, and SHALL check the WIDTH/TRITS constraint at elaboration.

Verification (TRITS=5, WIDTH=8)
REQ-031 SHALL cover this scenario: out_ready=1, trits 2,2,2,2,2 on consecutive cycles -> out_data=242 (0xF2), out_err=0, out_valid=1 for one cycle, 1 cycle after trit 5.
REQ-032 SHALL cover this scenario: trits 1,0,2,1,0 -> out_data=102; then immediately 0,0,0,0,1 -> out_data=1, with no bubble between frames.
REQ-033 SHALL cover this scenario: trits 0,ILLEGAL(2'b11),0,0,1 -> out_valid with out_err=1 and out_data=0; the following frame 0,0,0,1,0 -> 3, out_err=0.
REQ-034 SHALL cover this scenario: out_ready=0 after frame A=102 -> next frame's 4 trits accepted, in_ready=0 at trit 5, A held stable; raising out_ready -> A taken, trit 5 accepted the same cycle, next frame presented the following cycle.
REQ-035 SHALL cover this scenario: rst_n=0 for one cycle after 3 trits, then trits 0,0,0,0,1 -> out_data=1, with no earlier out_valid.
REQ-036 SHALL cover this scenario: random in_valid/out_ready with a reference model -> outputs match, in order, with no loss or duplication.
